bram_port_arbiter: RTL and testbench

Front-end controller placed directly upstream of the single-port synchronous BRAM (registered read, 1-cycle latency).
- Accepts an independent write stream and read-request stream, both valid/ready.
- Arbitrates them onto the single BRAM port.
- Tracks the in-flight read and returns read data on a valid/ready response stream, buffered so that response backpressure never loses data.

---
 rtl/bram_port_arbiter_pkg.sv | 13 +
 rtl/bram_port_arbiter_rsp_fifo2.sv | 57 +++++
 rtl/bram_port_arbiter.sv | 115 +++++++++++
 tb/tb_bram_port_arbiter.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bram_port_arbiter_pkg.sv
// bram_port_arbiter shared definitions.
// Grant encoding and response buffer depth.
package bram_port_arbiter_pkg;

    typedef enum logic [1:0] {
        GRANT_NONE = 2'd0,
        GRANT_WR   = 2'd1,
        GRANT_RD   = 2'd2
    } grant_e;

    localparam int RSP_DEPTH = 2;

endpackage

// File: rtl/bram_port_arbiter_rsp_fifo2.sv
// Two-entry in-order response buffer.
// Holds BRAM read data until the consumer takes it.
module rsp_fifo2
    import bram_port_arbiter_pkg::*;
#(
    parameter int data_width = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [data_width-1:0] din,
    input  logic                  pop,
    output logic [1:0]            count,
    output logic [data_width-1:0] head
);

    logic [data_width-1:0] slot0;
    logic [data_width-1:0] slot1;
    logic                  wr_ptr;
    logic                  rd_ptr;

    // Storage, pointers and occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot0  <= '0;
            slot1  <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                if (wr_ptr) slot1 <= din;
                else        slot0 <= din;
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            unique case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Oldest entry is always presented.
    always_comb begin
        head = rd_ptr ? slot1 : slot0;
    end

    // The credit rule upstream must keep a push away from a full buffer.
    assert property (@(posedge clk) disable iff (rst)
        !(push && count == 2'(RSP_DEPTH)))
        else $error("rsp_fifo2 overflow");

endmodule

// File: rtl/bram_port_arbiter.sv
// Single-port BRAM front end.
// Arbitrates write and read streams, buffers read responses.
module bram_port_arbiter
    import bram_port_arbiter_pkg::*;
#(
    parameter int addr_width = 10,
    parameter int data_width = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [addr_width-1:0] wr_addr,
    input  logic [data_width-1:0] wr_data,
    input  logic                  rd_req_valid,
    output logic                  rd_req_ready,
    input  logic [addr_width-1:0] rd_addr,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [data_width-1:0] rd_data,
    output logic                  bram_we,
    output logic [addr_width-1:0] bram_addr,
    output logic [data_width-1:0] bram_din,
    input  logic [data_width-1:0] bram_dout
);

    grant_e                grant;
    grant_e                last_grant;
    logic                  inflight;
    logic [addr_width-1:0] last_addr;
    logic [1:0]            fifo_count;
    logic [data_width-1:0] fifo_head;
    logic [1:0]            credit_sum;
    logic                  rd_ok;
    logic                  pop;

    // A read is only issued while a buffer slot is guaranteed for it.
    always_comb begin
        credit_sum = fifo_count + {1'b0, inflight};
        rd_ok      = rd_req_valid && (credit_sum < 2'd2);
    end

    // Grant selection; round-robin when both sides can go.
    always_comb begin
        grant = GRANT_NONE;
        if (rst) begin
            grant = GRANT_NONE;
        end else if (wr_valid && rd_ok) begin
            grant = (last_grant == GRANT_WR) ? GRANT_RD : GRANT_WR;
        end else if (wr_valid) begin
            grant = GRANT_WR;
        end else if (rd_ok) begin
            grant = GRANT_RD;
        end
    end

    // Drive handshakes and the BRAM port from the grant.
    always_comb begin
        wr_ready     = 1'b0;
        rd_req_ready = 1'b0;
        bram_we      = 1'b0;
        bram_addr    = last_addr;
        bram_din     = '0;
        unique case (grant)
            GRANT_WR: begin
                wr_ready  = 1'b1;
                bram_we   = 1'b1;
                bram_addr = wr_addr;
                bram_din  = wr_data;
            end
            GRANT_RD: begin
                rd_req_ready = 1'b1;
                bram_addr    = rd_addr;
            end
            default: begin
                bram_addr = last_addr;
            end
        endcase
    end

    // Track the outstanding read, last winner and last address.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight   <= 1'b0;
            last_grant <= GRANT_RD;
            last_addr  <= '0;
        end else begin
            inflight <= (grant == GRANT_RD);
            if (grant != GRANT_NONE) begin
                last_grant <= grant;
                last_addr  <= bram_addr;
            end
        end
    end

    // Response stream handshake.
    always_comb begin
        rd_valid = (fifo_count != 2'd0);
        rd_data  = fifo_head;
        pop      = rd_valid && rd_ready;
    end

    rsp_fifo2 #(
        .data_width(data_width)
    ) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (inflight),
        .din  (bram_dout),
        .pop  (pop),
        .count(fifo_count),
        .head (fifo_head)
    );

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Directed bench for bram_port_arbiter.
// Includes a registered-read single-port BRAM model.
module tb_bram_port_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_valid;
    logic       wr_ready;
    logic [9:0] wr_addr;
    logic [7:0] wr_data;
    logic       rd_req_valid;
    logic       rd_req_ready;
    logic [9:0] rd_addr;
    logic       rd_valid;
    logic       rd_ready;
    logic [7:0] rd_data;
    logic       bram_we;
    logic [9:0] bram_addr;
    logic [7:0] bram_din;
    logic [7:0] bram_dout;

    logic [7:0] mem [0:1023];
    logic [7:0] expq [$];

    int n_checks = 0;
    int n_errors = 0;
    int widx;
    int ridx;
    int raddr;
    int n;

    always #5 clk = ~clk;

    bram_port_arbiter #(
        .addr_width(10),
        .data_width(8)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .rd_req_valid(rd_req_valid),
        .rd_req_ready(rd_req_ready),
        .rd_addr     (rd_addr),
        .rd_valid    (rd_valid),
        .rd_ready    (rd_ready),
        .rd_data     (rd_data),
        .bram_we     (bram_we),
        .bram_addr   (bram_addr),
        .bram_din    (bram_din),
        .bram_dout   (bram_dout)
    );

    // Single-port BRAM, read-first, one cycle read latency.
    always @(posedge clk) begin
        if (bram_we) mem[bram_addr] <= bram_din;
        bram_dout <= mem[bram_addr];
    end

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Every accepted response must match the next expected value.
    always @(negedge clk) begin
        if (!rst && rd_valid && rd_ready) begin
            if (expq.size() == 0)
                check("rsp_unexpected", 32'(rd_data), 32'hFFFF_FFFF);
            else
                check("rsp_data", 32'(rd_data), 32'(expq.pop_front()));
        end
    end

    task automatic drain();
        int k;
        k = 0;
        while (expq.size() != 0 && k < 20) begin
            @(negedge clk);
            k++;
        end
        @(negedge clk);
        check("drain_empty", expq.size(), 0);
    endtask

    initial begin
        // 1: reset with both requests pending
        rst          = 1'b1;
        wr_valid     = 1'b1;
        rd_req_valid = 1'b1;
        wr_addr      = 10'h003;
        wr_data      = 8'hA5;
        rd_addr      = 10'h003;
        rd_ready     = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_wr_ready", wr_ready, 0);
            check("rst_rd_req_ready", rd_req_ready, 0);
            check("rst_bram_we", bram_we, 0);
            check("rst_rd_valid", rd_valid, 0);
            check("rst_rd_data", rd_data, 0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("first_grant_wr", wr_ready, 1);
        check("first_grant_rd", rd_req_ready, 0);
        check("first_we", bram_we, 1);
        check("first_addr", bram_addr, 10'h003);
        check("first_din", bram_din, 8'hA5);

        // 2: read back the address just written
        @(posedge clk); #1;
        wr_valid = 1'b0;
        @(negedge clk);
        check("rd_grant", rd_req_ready, 1);
        check("rd_we", bram_we, 0);
        check("rd_addr_out", bram_addr, 10'h003);
        if (rd_req_ready) expq.push_back(8'hA5);
        @(posedge clk); #1;
        rd_req_valid = 1'b0;
        @(negedge clk);
        check("lat_cycle1", rd_valid, 0);
        @(negedge clk);
        check("lat_cycle2", rd_valid, 1);
        check("lat_data", rd_data, 8'hA5);
        @(negedge clk);
        check("lat_popped", rd_valid, 0);

        // 3: both streams always valid, grants alternate
        widx = 0;
        ridx = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            wr_valid     = 1'b1;
            rd_req_valid = 1'b1;
            wr_addr      = 10'(32'h20 + widx);
            wr_data      = 8'(32'h40 + widx);
            rd_addr      = 10'(32'h20 + ridx);
            @(negedge clk);
            check("alt_wr", wr_ready, (i % 2 == 0));
            check("alt_rd", rd_req_ready, (i % 2 == 1));
            if (wr_ready) widx++;
            if (rd_req_ready) begin
                expq.push_back(8'(32'h40 + ridx));
                ridx++;
            end
        end
        @(posedge clk); #1;
        wr_valid     = 1'b0;
        rd_req_valid = 1'b0;
        drain();

        // 4: preload, then reads against a stalled consumer
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            wr_valid = 1'b1;
            wr_addr  = 10'(k);
            wr_data  = 8'(32'h10 + k);
            @(negedge clk);
            check("preload_wr", wr_ready, 1);
        end
        raddr = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            wr_valid     = 1'b0;
            rd_ready     = 1'b0;
            rd_req_valid = 1'b1;
            rd_addr      = 10'(raddr);
            @(negedge clk);
            check("bp_accept", rd_req_ready, (i < 2));
            if (rd_req_ready) begin
                expq.push_back(8'(32'h10 + raddr));
                raddr++;
            end
        end
        check("bp_full_valid", rd_valid, 1);
        check("bp_full_head", rd_data, 8'h10);
        n = 0;
        while (raddr < 4 && n < 20) begin
            @(posedge clk); #1;
            rd_ready     = 1'b1;
            rd_req_valid = 1'b1;
            rd_addr      = 10'(raddr);
            @(negedge clk);
            if (rd_req_ready) begin
                expq.push_back(8'(32'h10 + raddr));
                raddr++;
            end
            n++;
        end
        @(posedge clk); #1;
        rd_req_valid = 1'b0;
        check("bp_all_accepted", raddr, 4);
        drain();

        // 5: reset between acceptance and the push edge
        @(posedge clk); #1;
        rd_req_valid = 1'b1;
        rd_addr      = 10'h005;
        @(negedge clk);
        check("rstmid_accept", rd_req_ready, 1);
        @(posedge clk); #1;
        rd_req_valid = 1'b0;
        rst          = 1'b1;
        @(negedge clk);
        check("rstmid_valid", rd_valid, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("rstmid_no_rsp", rd_valid, 0);
        end
        check("rstmid_count", u_dut.u_fifo.count, 0);

        // 6: top address, all-ones data
        @(posedge clk); #1;
        wr_valid = 1'b1;
        wr_addr  = 10'h3FF;
        wr_data  = 8'hFF;
        @(negedge clk);
        check("max_wr", wr_ready, 1);
        check("max_wr_addr", bram_addr, 10'h3FF);
        @(posedge clk); #1;
        wr_valid     = 1'b0;
        rd_req_valid = 1'b1;
        rd_addr      = 10'h3FF;
        @(negedge clk);
        check("max_rd", rd_req_ready, 1);
        check("max_rd_addr", bram_addr, 10'h3FF);
        if (rd_req_ready) expq.push_back(8'hFF);
        @(posedge clk); #1;
        rd_req_valid = 1'b0;
        rd_addr      = 10'h000;
        @(negedge clk);
        check("idle_addr_hold", bram_addr, 10'h3FF);
        check("idle_we", bram_we, 0);
        check("idle_din", bram_din, 0);
        drain();

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
